processador_multiciclo: RTL and testbench

Multicycle MIPS-subset core, successor to the single-cycle processor. Replaces the separate instruction and data memories with one shared memory port using a req/ready handshake. Instructions execute through a state machine that tolerates variable memory latency. Width, reset vector and register-file depth are parametrised.

---
 rtl/processador_multiciclo_pkg.sv | 17 +
 rtl/processador_multiciclo_if.sv | 10 +
 rtl/processador_multiciclo_banco_regs.sv | 23 ++
 rtl/processador_multiciclo.sv | 110 +++++++++++
 tb/tb_processador_multiciclo.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/processador_multiciclo_pkg.sv
// proc_pkg: opcodes, functs, FSM states and ALU control codes shared by the multicycle core
// Exports: OP_* opcodes, F_* R-type functs, ALU_* 4-bit controls, state_t, alu_ctl()
package proc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
  typedef enum logic [2:0] {RST, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  function automatic logic [3:0] alu_ctl(input logic [5:0] op, input logic [5:0] funct);
    return op != OP_RTYPE ? ALU_ADD :
           funct == F_SUB ? ALU_SUB :
           funct == F_AND ? ALU_AND :
           funct == F_OR  ? ALU_OR  :
           funct == F_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/processador_multiciclo_if.sv
// processador_multiciclo_if: shared instruction/data memory port with req/ready handshake
// master (core): drives mem_req, mem_we, mem_addr, mem_wdata; samples mem_rdata, mem_ready
// slave (memory): the mirror image
interface processador_multiciclo_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/processador_multiciclo_banco_regs.sv
// banco_regs: NREG x DATA_W register file, two async read ports, one sync write port, r0 hardwired 0
// Ports: clk, we, ra1/ra2/wa (5-bit, high bits ignored when NREG < 32), wd, rd1/rd2
module banco_regs #(parameter int DATA_W = 32, parameter int NREG = 32) (
  input  logic              clk,
  input  logic              we,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  localparam int IW = $clog2(NREG);
  logic [DATA_W-1:0] regs [NREG];
  logic [IW-1:0] i1, i2, iw;
  assign i1 = ra1[IW-1:0];
  assign i2 = ra2[IW-1:0];
  assign iw = wa[IW-1:0];
  assign rd1 = i1 == '0 ? '0 : regs[i1];
  assign rd2 = i2 == '0 ? '0 : regs[i2];
  always_ff @(posedge clk)
    if (we && iw != '0) regs[iw] <= wd;
endmodule

// File: rtl/processador_multiciclo.sv
// processador_multiciclo: multicycle MIPS-subset core on a single shared req/ready memory port
// Ports: clk, reset (async, active-high), mem (processador_multiciclo_if.master), pc_o (debug PC),
//        halted (sticky illegal-instruction flag)
// Build option: define PROC_JUMP_EN to decode opcode 0x02 as j; otherwise it halts as illegal.
module processador_multiciclo
  import proc_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              NREG     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  processador_multiciclo_if.master  mem,
  output logic [ADDR_W-1:0]         pc_o,
  output logic                      halted
);
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic [31:0] ir;
  logic [DATA_W-1:0] a, b, aluout, mdr, simm_r, simm, rd1, rd2, alu_b, alu_y;
  logic [5:0] op, funct;
  logic [3:0] ctl;
  logic rtype_ok, legal;
  assign op = ir[31:26];
  assign funct = ir[5:0];
  assign simm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign ctl = alu_ctl(op, funct);
  assign rtype_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
`ifdef PROC_JUMP_EN
  logic [ADDR_W-1:0] jt;
  // keep the top PC nibble, splice in the 26-bit word index
  assign jt = (pc & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir[25:0], 2'b00});
  assign legal = op == OP_RTYPE ? rtype_ok : op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
`else
  assign legal = op == OP_RTYPE ? rtype_ok : op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI};
`endif
  assign alu_b = op == OP_RTYPE ? b : simm_r;
  always_comb
    alu_y = ctl == ALU_AND ? a & alu_b :
            ctl == ALU_OR  ? a | alu_b :
            ctl == ALU_SUB ? a - alu_b :
            ctl == ALU_SLT ? {{(DATA_W-1){1'b0}}, $signed(a) < $signed(alu_b)} : a + alu_b;
  banco_regs #(.DATA_W(DATA_W), .NREG(NREG)) u_regs (
    .clk(clk),
    .we(state == WB),
    .ra1(ir[25:21]),
    .ra2(ir[20:16]),
    .wa(op == OP_RTYPE ? ir[15:11] : ir[20:16]),
    .wd(op == OP_LW ? mdr : aluout),
    .rd1(rd1),
    .rd2(rd2)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= RST;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      simm_r <= '0;
    end else
      case (state)
        RST: state <= FETCH;
        FETCH: if (mem.mem_ready) begin
          ir    <= mem.mem_rdata[31:0];
          pc    <= pc + ADDR_W'(4);
          state <= DECODE;
        end
        DECODE: begin
          a      <= rd1;
          b      <= rd2;
          simm_r <= simm;
          // pc already points past this instruction, so this is the beq target
          aluout <= DATA_W'(pc) + (simm << 2);
          state  <= legal ? EXEC : HALT;
        end
        EXEC:
          if (op == OP_BEQ) begin
            if (a == b) pc <= ADDR_W'(aluout);
            state <= FETCH;
          end
`ifdef PROC_JUMP_EN
          else if (op == OP_J) begin
            pc    <= jt;
            state <= FETCH;
          end
`endif
          else begin
            aluout <= alu_y;
            state  <= op == OP_LW || op == OP_SW ? MEM : WB;
          end
        MEM: if (mem.mem_ready) begin
          mdr   <= mem.mem_rdata;
          state <= op == OP_SW ? FETCH : WB;
        end
        WB: state <= FETCH;
        default: ;
      endcase
  // memory outputs decode from state only, so reset drops mem_req at once and mem_ready never reaches them
  assign mem.mem_req   = state == FETCH || state == MEM;
  assign mem.mem_we    = state == MEM && op == OP_SW;
  assign mem.mem_addr  = state == MEM ? ADDR_W'(aluout) : state == FETCH ? pc : '0;
  assign mem.mem_wdata = mem.mem_we ? b : '0;
  assign pc_o   = pc;
  assign halted = state == HALT;
endmodule

// File: tb/tb_processador_multiciclo.sv
// tb_processador_multiciclo: program-driven bench with a write scoreboard and a wait-state memory model
module tb_processador_multiciclo;
  import proc_pkg::*;
  localparam logic [31:0] NOP = 32'h2000_0000;
  logic clk = 0, reset = 1;
  logic [31:0] pc_o;
  logic halted;
  processador_multiciclo_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  processador_multiciclo #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h100), .NREG(32)) dut (
    .clk(clk), .reset(reset), .mem(bus.master), .pc_o(pc_o), .halted(halted));
  always #5 clk = ~clk;
  logic [31:0] ram [256];
  logic [31:0] prog[$];
  logic [31:0] rd_addr[$], exp_addr[$], exp_data[$];
  int rd_cyc[$];
  int waits = 0, cnt = 0, cyc = 0, n_cmp = 0, n_err = 0;
  logic [31:0] ref_addr, ref_wdata, ea, ed;
  logic ref_we;
  always @(posedge clk) cyc++;
  // memory model: decides mem_ready at the negedge ahead of the completing posedge
  always @(negedge clk)
    if (!bus.mem_req) begin
      bus.mem_ready = 0;
      cnt = 0;
    end else begin
      if (cnt == 0) begin
        ref_addr = bus.mem_addr; ref_we = bus.mem_we; ref_wdata = bus.mem_wdata;
      end else begin
        n_cmp++;
        if (bus.mem_addr !== ref_addr || bus.mem_we !== ref_we || bus.mem_wdata !== ref_wdata) begin
          n_err++;
          $display("FAIL hold_stable: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                   bus.mem_addr, bus.mem_we, bus.mem_wdata, ref_addr, ref_we, ref_wdata);
        end
      end
      if (cnt >= waits) begin
        bus.mem_ready = 1;
        cnt = 0;
        if (bus.mem_we) begin
          ram[bus.mem_addr[9:2]] = bus.mem_wdata;
          n_cmp++;
          if (exp_addr.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected: addr=%h data=%h required none", bus.mem_addr, bus.mem_wdata);
          end else begin
            ea = exp_addr.pop_front(); ed = exp_data.pop_front();
            if (bus.mem_addr !== ea || bus.mem_wdata !== ed) begin
              n_err++;
              $display("FAIL write: addr=%h data=%h required addr=%h data=%h", bus.mem_addr, bus.mem_wdata, ea, ed);
            end
          end
        end else begin
          bus.mem_rdata = ram[bus.mem_addr[9:2]];
          rd_addr.push_back(bus.mem_addr);
          rd_cyc.push_back(cyc);
        end
      end else begin
        bus.mem_ready = 0;
        cnt++;
      end
    end
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  task automatic hold_reset;
    @(posedge clk); #2 reset = 1;
    rd_addr.delete(); rd_cyc.delete(); exp_addr.delete(); exp_data.delete(); prog.delete();
    for (int i = 0; i < 256; i++) ram[i] = NOP;
  endtask
  task automatic release_reset(input int w);
    for (int i = 0; i < prog.size(); i++) ram[64 + i] = prog[i];
    waits = w;
    @(posedge clk); #2 reset = 0;
  endtask
  task automatic wait_reads(input int n, input int budget, output bit ok);
    while (rd_addr.size() < n && budget > 0) begin @(posedge clk); #2; budget--; end
    ok = rd_addr.size() >= n;
  endtask
  task automatic wait_writes(input int budget, output bit ok);
    while (exp_addr.size() > 0 && budget > 0) begin @(posedge clk); #2; budget--; end
    ok = exp_addr.size() == 0;
  endtask
  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
    exp_addr.push_back(addr); exp_data.push_back(data);
  endtask
  task automatic test_reset;
    bit ok;
    int budget;
    hold_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: %b required 0", bus.mem_req); end
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL reset_pc: %h required 00000100", pc_o); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: %b required 0", halted); end
    release_reset(3);
    wait_reads(1, 50, ok);
    n_cmp++; if (!ok || rd_addr[0] !== 32'h100) begin n_err++; $display("FAIL first_fetch: ok=%b addr=%h required 00000100", ok, ok ? rd_addr[0] : 32'hx); end
    n_cmp++; if (pc_o !== 32'h104) begin n_err++; $display("FAIL pc_after_fetch: %h required 00000104", pc_o); end
    budget = 20;
    while (bus.mem_req !== 1'b1 && budget > 0) begin @(posedge clk); #2; budget--; end
    reset = 1;
    #1;
    n_cmp++; if (budget == 0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL midrun_req: req=%b budget=%0d required req 0", bus.mem_req, budget); end
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL midrun_pc: %h required 00000100", pc_o); end
    rd_addr.delete(); rd_cyc.delete();
    @(posedge clk); #2 reset = 0;
    wait_reads(1, 50, ok);
    n_cmp++; if (!ok || rd_addr[0] !== 32'h100) begin n_err++; $display("FAIL refetch: ok=%b addr=%h required 00000100", ok, ok ? rd_addr[0] : 32'hx); end
  endtask
  task automatic test_arith;
    bit ok;
    int x = 5, y = -3, d;
    hold_reset();
    prog = {enc_i(OP_ADDI, 0, 1, 5), enc_i(OP_ADDI, 0, 2, -3), enc_r(1, 2, 3, F_ADD), enc_r(2, 1, 4, F_SLT),
            enc_r(1, 2, 7, F_SLT), enc_r(1, 2, 8, F_SUB), enc_r(1, 2, 9, F_AND), enc_r(1, 2, 10, F_OR),
            enc_i(OP_SW, 0, 3, 'h40), enc_i(OP_SW, 0, 4, 'h44), enc_i(OP_SW, 0, 7, 'h48),
            enc_i(OP_SW, 0, 8, 'h4C), enc_i(OP_SW, 0, 9, 'h50), enc_i(OP_SW, 0, 10, 'h54),
            enc_i(OP_BEQ, 0, 0, -1)};
    push_exp(32'h40, 32'(x + y));
    push_exp(32'h44, (y < x) ? 32'd1 : 32'd0);
    push_exp(32'h48, (x < y) ? 32'd1 : 32'd0);
    push_exp(32'h4C, 32'(x - y));
    push_exp(32'h50, 32'(x & y));
    push_exp(32'h54, 32'(x | y));
    release_reset(0);
    wait_reads(5, 200, ok);
    d = ok ? rd_cyc[4] - rd_cyc[0] : -1;
    n_cmp++; if (d !== 16) begin n_err++; $display("FAIL arith_cycles: %0d required 16", d); end
    wait_writes(500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL arith_writes: %0d pending required 0", exp_addr.size()); end
  endtask
  task automatic test_loadstore;
    bit ok;
    int d_sw, d_lw;
    hold_reset();
    prog = {enc_i(OP_ADDI, 0, 1, 5), enc_i(OP_SW, 0, 1, 8), enc_i(OP_LW, 0, 5, 8),
            enc_i(OP_SW, 0, 5, 'h48), enc_i(OP_BEQ, 0, 0, -1)};
    ram[2] = 32'h0;
    push_exp(32'h8, 32'd5);
    push_exp(32'h48, 32'd5);
    release_reset(3);
    wait_reads(5, 300, ok);
    n_cmp++; if (!ok || rd_addr[3] !== 32'h8) begin n_err++; $display("FAIL lw_addr: ok=%b addr=%h required 00000008", ok, ok ? rd_addr[3] : 32'hx); end
    d_sw = ok ? rd_cyc[2] - rd_cyc[1] : -1;
    d_lw = ok ? rd_cyc[4] - rd_cyc[2] : -1;
    n_cmp++; if (d_sw !== 10) begin n_err++; $display("FAIL sw_wait_cycles: %0d required 10", d_sw); end
    n_cmp++; if (d_lw !== 11) begin n_err++; $display("FAIL lw_wait_cycles: %0d required 11", d_lw); end
    wait_writes(500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ls_writes: %0d pending required 0", exp_addr.size()); end
  endtask
  task automatic test_branch;
    bit ok;
    int d;
    logic [31:0] exp_pc [7] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h20, 32'h20, 32'h20};
    hold_reset();
    prog = {enc_i(OP_ADDI, 0, 1, 7), enc_i(OP_ADDI, 0, 2, 9), enc_i(OP_BEQ, 1, 2, 4), enc_i(OP_BEQ, 0, 0, -60)};
    ram[8] = enc_i(OP_BEQ, 1, 1, -1);
    release_reset(0);
    wait_reads(7, 200, ok);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (!ok || rd_addr[i] !== exp_pc[i]) begin n_err++; $display("FAIL branch_fetch[%0d]: ok=%b addr=%h required %h", i, ok, ok ? rd_addr[i] : 32'hx, exp_pc[i]); end
    end
    d = ok ? rd_cyc[3] - rd_cyc[2] : -1;
    n_cmp++; if (d !== 3) begin n_err++; $display("FAIL beq_cycles: %0d required 3", d); end
  endtask
  task automatic test_reg0_wrap;
    bit ok;
    logic [31:0] e = 32'h7FFF;
    hold_reset();
    prog = {enc_i(OP_ADDI, 0, 1, 5), enc_r(1, 1, 0, F_ADD), enc_i(OP_SW, 0, 0, 'h60), enc_i(OP_ADDI, 0, 6, 'h7FFF)};
    repeat (18) begin prog.push_back(enc_r(6, 6, 6, F_ADD)); e = e + e; end
    prog = {prog, enc_i(OP_SW, 0, 6, 'h64), enc_i(OP_ADDI, 0, 7, -1), enc_i(OP_ADDI, 7, 7, 1),
            enc_i(OP_SW, 0, 7, 'h68), enc_i(OP_ADDI, 0, 11, 'h7FFF), enc_i(OP_ADDI, 11, 11, 'h7FFF),
            enc_i(OP_SW, 0, 11, 'h6C), enc_i(OP_BEQ, 0, 0, -1)};
    push_exp(32'h60, 32'h0);
    push_exp(32'h64, e);
    push_exp(32'h68, 32'h0);
    push_exp(32'h6C, 32'hFFFE);
    release_reset(1);
    wait_writes(2000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_writes: %0d pending required 0", exp_addr.size()); end
  endtask
  task automatic test_illegal;
    bit ok;
    int bad = 0;
    hold_reset();
    prog = {enc_i(OP_ADDI, 0, 1, 1), 32'hFC00_0000};
    release_reset(0);
    wait_reads(2, 50, ok);
    n_cmp++; if (!ok || halted !== 1'b0) begin n_err++; $display("FAIL halt_in_decode: ok=%b halted=%b required 0", ok, halted); end
    @(posedge clk); #2;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set: %b required 1", halted); end
    repeat (10) begin
      @(posedge clk); #2;
      if (bus.mem_req !== 1'b0 || pc_o !== 32'h108 || halted !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL halt_frozen: %0d bad cycles (req=%b pc=%h) required 0", bad, bus.mem_req, pc_o); end
    n_cmp++; if (rd_addr.size() !== 2) begin n_err++; $display("FAIL halt_no_fetch: %0d reads required 2", rd_addr.size()); end
  endtask
  task automatic test_jump;
    bit ok;
    hold_reset();
    prog = {enc_i(OP_ADDI, 0, 1, 1), {OP_J, 26'h40}};
    release_reset(0);
`ifdef PROC_JUMP_EN
    wait_reads(4, 100, ok);
    n_cmp++; if (!ok || rd_addr[2] !== 32'h100) begin n_err++; $display("FAIL jump_target: ok=%b addr=%h required 00000100", ok, ok ? rd_addr[2] : 32'hx); end
    n_cmp++; if (!ok || rd_cyc[2] - rd_cyc[1] !== 3) begin n_err++; $display("FAIL jump_cycles: ok=%b required 3", ok); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL jump_halted: %b required 0", halted); end
`else
    wait_reads(2, 50, ok);
    repeat (5) @(posedge clk);
    #2;
    n_cmp++; if (!ok || halted !== 1'b1) begin n_err++; $display("FAIL j_illegal: ok=%b halted=%b required 1", ok, halted); end
    n_cmp++; if (rd_addr.size() !== 2 || pc_o !== 32'h108) begin n_err++; $display("FAIL j_frozen: reads=%0d pc=%h required 2 / 00000108", rd_addr.size(), pc_o); end
`endif
  endtask
  initial begin
    bus.mem_ready = 0;
    bus.mem_rdata = '0;
    test_reset();
    test_arith();
    test_loadstore();
    test_branch();
    test_reg0_wrap();
    test_illegal();
    test_jump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
